// File: rtl/fe_redirect_if.sv
// AGEX branch-resolution inputs and fetch-side outputs of the redirect unit.
interface fe_redirect_if #(
  parameter int unsigned DBITS = 32
);
  logic             agex_br_valid;
  logic             agex_br_taken;
  logic [DBITS-1:0] agex_br_target;
  logic [DBITS-1:0] agex_br_pc;
  logic             agex_pred_taken;
  logic [DBITS-1:0] agex_pred_target;
  logic             de_stall;
  logic [DBITS-1:0] fe_pc;
  logic             fe_valid;
  logic             fe_pred_taken;
  logic [DBITS-1:0] fe_pred_target;
  logic             squash;
  logic [15:0]      redirect_count;

  modport master (
    output agex_br_valid, agex_br_taken, agex_br_target, agex_br_pc,
           agex_pred_taken, agex_pred_target, de_stall,
    input  fe_pc, fe_valid, fe_pred_taken, fe_pred_target, squash, redirect_count
  );

  modport slave (
    input  agex_br_valid, agex_br_taken, agex_br_target, agex_br_pc,
           agex_pred_taken, agex_pred_target, de_stall,
    output fe_pc, fe_valid, fe_pred_taken, fe_pred_target, squash, redirect_count
  );
endinterface

// File: rtl/fe_redirect_unit.sv
// Fetch PC owner: direct-mapped BTB prediction, AGEX mispredict redirect and refill bubble.
module fe_redirect_unit #(
  parameter int unsigned       DBITS        = 32,
  parameter logic [DBITS-1:0]  RESET_PC     = '0,
  parameter int unsigned       BTB_IDX_BITS = 4,
  parameter int unsigned       FLUSH_CYCLES = 1
) (
  input  logic         clk,
  input  logic         reset,
  fe_redirect_if.slave bus
);
  localparam int unsigned ENTRIES  = 1 << BTB_IDX_BITS;
  localparam int unsigned TAG_BITS = DBITS - BTB_IDX_BITS - 2;
  localparam int unsigned FCTR_W   = 3;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  typedef struct packed {
    logic                valid;
    logic [TAG_BITS-1:0] tag;
    logic [DBITS-1:0]    target;
    logic [1:0]          ctr;
  } btb_entry_t;

  state_t            state_q, state_d;
  logic [DBITS-1:0]  pc_q, pc_d;
  logic [FCTR_W-1:0] fctr_q, fctr_d;
  logic              valid_q;
  logic [15:0]       rcnt_q;
  btb_entry_t        btb_q [ENTRIES];

  // BTB lookup on the current fetch PC (sees pre-update contents)
  logic [BTB_IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0]     lk_tag;
  btb_entry_t              lk_e;
  logic                    lk_hit, pred_taken;
  logic [DBITS-1:0]        pred_target;

  assign lk_idx      = pc_q[BTB_IDX_BITS+1:2];
  assign lk_tag      = pc_q[DBITS-1:BTB_IDX_BITS+2];
  assign lk_e        = btb_q[lk_idx];
  assign lk_hit      = lk_e.valid && (lk_e.tag == lk_tag);
  assign pred_taken  = lk_hit && lk_e.ctr[1];
  assign pred_target = pred_taken ? lk_e.target : '0;

  // Resolution check against the prediction carried down the pipe
  logic             mispredict;
  logic [DBITS-1:0] correct_pc;

  assign mispredict = bus.agex_br_valid &&
                      ((bus.agex_br_taken != bus.agex_pred_taken) ||
                       (bus.agex_br_taken && (bus.agex_br_target != bus.agex_pred_target)));
  assign correct_pc = bus.agex_br_taken ? bus.agex_br_target : bus.agex_br_pc + DBITS'(4);

  logic [BTB_IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0]     up_tag;
  btb_entry_t              up_e;
  logic                    up_hit;

  assign up_idx = bus.agex_br_pc[BTB_IDX_BITS+1:2];
  assign up_tag = bus.agex_br_pc[DBITS-1:BTB_IDX_BITS+2];
  assign up_e   = btb_q[up_idx];
  assign up_hit = up_e.valid && (up_e.tag == up_tag);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      fctr_q  <= '0;
      valid_q <= 1'b0;
      rcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      fctr_q  <= fctr_d;
      valid_q <= (state_d == RUN);
      if (mispredict && (rcnt_q != 16'hFFFF)) rcnt_q <= rcnt_q + 16'd1;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    fctr_d  = fctr_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        // The resolving branch is older than any stalled instruction, so it wins
        if (mispredict) begin
          pc_d    = correct_pc;
          fctr_d  = FCTR_W'(FLUSH_CYCLES - 1);
          state_d = FLUSH;
        end else if (bus.de_stall) begin
          pc_d = pc_q;
        end else if (pred_taken) begin
          pc_d = pred_target;
        end else begin
          pc_d = pc_q + DBITS'(4);
        end
      end
      FLUSH: begin
        if (mispredict) begin
          pc_d   = correct_pc;
          fctr_d = FCTR_W'(FLUSH_CYCLES - 1);
        end else if (fctr_q == '0) begin
          state_d = RUN;
        end else begin
          fctr_d = fctr_q - FCTR_W'(1);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // BTB training: allocate on taken miss, 2-bit saturating counter on hit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(ENTRIES); i++) btb_q[i] <= '0;
    end else if (bus.agex_br_valid) begin
      if (up_hit) begin
        if (bus.agex_br_taken) begin
          btb_q[up_idx].target <= bus.agex_br_target;
          if (up_e.ctr != 2'b11) btb_q[up_idx].ctr <= up_e.ctr + 2'd1;
        end else if (up_e.ctr != 2'b00) begin
          btb_q[up_idx].ctr <= up_e.ctr - 2'd1;
        end
      end else if (bus.agex_br_taken) begin
        btb_q[up_idx] <= '{valid: 1'b1, tag: up_tag, target: bus.agex_br_target, ctr: 2'b10};
      end
    end
  end

  assign bus.fe_pc          = pc_q;
  assign bus.fe_valid       = valid_q;
  assign bus.fe_pred_taken  = pred_taken;
  assign bus.fe_pred_target = pred_target;
  assign bus.squash         = mispredict;
  assign bus.redirect_count = rcnt_q;
endmodule
